// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: one LFSR-reloaded spawn timer per slot, shared frame tick, one grant per tick,
// requests held until acknowledged. Define SPAWN_DIFFICULTY_EN to shorten reload intervals by `level`.

module enemy_spawn_slot #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] CNT_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gtick_i,
  input  logic             pause_i,
  input  logic             grant_i,
  input  logic             ack_i,
  input  logic             active_i,
  input  logic [CNT_W-1:0] reload_i,
  output logic             req_o,
  output logic             elig_o
);
  typedef enum logic [1:0] {ST_ARMED, ST_REQ, ST_IDLE} slot_st_e;

  slot_st_e         st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_ARMED;
      cnt_q <= CNT_RST;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Ack beats a pause; a pause re-arms with cnt=0 so the slot competes again on resume.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_ARMED: begin
        if (grant_i) st_d = ST_REQ;
        else if (gtick_i && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ST_REQ: begin
        if (ack_i) st_d = ST_IDLE;
        else if (pause_i) begin
          st_d  = ST_ARMED;
          cnt_d = '0;
        end else if (active_i) st_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!active_i) begin
          st_d  = ST_ARMED;
          cnt_d = reload_i;
        end
      end
      default: st_d = ST_ARMED;
    endcase
  end

  assign req_o  = (st_q == ST_REQ);
  assign elig_o = (st_q == ST_ARMED) && (cnt_q == '0);
endmodule

module enemy_spawn_scheduler #(
  parameter int          NBR_ENEMIES = 8,
  parameter int          CNT_W       = 4,
  parameter int          GLOBAL_DIV  = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [2:0]  PLAY_STATE  = 3'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   pixel_0_line_0,
  input  logic [2:0]             state,
  input  logic [1:0]             level,
  input  logic [NBR_ENEMIES-1:0] slot_active,
  input  logic [NBR_ENEMIES-1:0] spawn_ack,
  output logic [NBR_ENEMIES-1:0] spawn_req
);
  localparam int               DIV_W    = (GLOBAL_DIV > 1) ? $clog2(GLOBAL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GLOBAL_DIV - 1);

  logic [15:0]                       lfsr_q, lfsr_d;
  logic [DIV_W-1:0]                  div_q, div_d;
  logic                              play, frame, gtick;
  logic [NBR_ENEMIES-1:0]            elig, grant;
  logic [NBR_ENEMIES-1:0][CNT_W-1:0] reload;

  assign play  = (state == PLAY_STATE);
  assign frame = enb & pixel_0_line_0 & play;
  assign gtick = frame & (div_q == DIV_LAST);

  always_comb begin
    lfsr_d = lfsr_q;
    div_d  = div_q;
    if (pixel_0_line_0)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (frame)
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      div_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      div_q  <= div_d;
    end
  end

  // Lowest set bit of elig wins; the rest wait for the next tick.
  assign grant = gtick ? (elig & (~elig + NBR_ENEMIES'(1))) : '0;

  for (genvar i = 0; i < NBR_ENEMIES; i++) begin : g_slot
    localparam int OFF = i % (17 - CNT_W);
    logic [CNT_W-1:0] slice, base;

    assign slice = lfsr_q[OFF +: CNT_W];
    assign base  = (slice == '0) ? CNT_W'(1) : slice;
`ifdef SPAWN_DIFFICULTY_EN
    logic [CNT_W-1:0] scaled;
    assign scaled    = base >> level;
    assign reload[i] = (scaled == '0) ? CNT_W'(1) : scaled;
`else
    assign reload[i] = base;
`endif

    enemy_spawn_slot #(
      .CNT_W  (CNT_W),
      .CNT_RST(CNT_W'(2 * i + 1))
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .gtick_i (gtick),
      .pause_i (~play),
      .grant_i (grant[i]),
      .ack_i   (spawn_ack[i]),
      .active_i(slot_active[i]),
      .reload_i(reload[i]),
      .req_o   (spawn_req[i]),
      .elig_o  (elig[i])
    );
  end

`ifndef SPAWN_DIFFICULTY_EN
  logic unused_level;
  assign unused_level = ^level;
`endif
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: behavioural model feeds an expected-request queue, a negedge
// monitor pops and compares; directed scenarios add fixed-value checks.

module tb_enemy_spawn_scheduler;
  localparam int          N    = 8;
  localparam int          CW   = 4;
  localparam int          GDIV = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [2:0]  PLAY = 3'd1;

  logic         clk = 1'b0, rst = 1'b1, enb = 1'b1, p0l0 = 1'b0;
  logic [2:0]   state = PLAY;
  logic [1:0]   level = 2'd0;
  logic [N-1:0] slot_active = '0, ack_drv = '0, tie_mask = '0;
  logic [N-1:0] spawn_ack, spawn_req;
  int           checks = 0, errors = 0;

  assign spawn_ack = (spawn_req & tie_mask) | ack_drv;
  always #5 clk = ~clk;

  enemy_spawn_scheduler #(
    .NBR_ENEMIES(N), .CNT_W(CW), .GLOBAL_DIV(GDIV), .LFSR_SEED(SEED), .PLAY_STATE(PLAY)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .pixel_0_line_0(p0l0), .state(state), .level(level),
    .slot_active(slot_active), .spawn_ack(spawn_ack), .spawn_req(spawn_req)
  );

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each slot is waiting (countdown), requesting, or dead-waiting for slot_active low.
  int           m_cnt[N];
  bit           m_req[N];
  bit           m_idle[N];
  int           m_div;
  logic [15:0]  m_lfsr;
  logic [N-1:0] exp_q[$];

  function void m_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 2 * i + 1; m_req[i] = 0; m_idle[i] = 0;
    end
    m_div = 0; m_lfsr = SEED;
  endfunction

  function logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_req[i];
    return v;
  endfunction

  function int m_reload(int i);
    logic [15:0] sh;
    int r;
    sh = m_lfsr >> (i % (17 - CW));
    r = int'(sh) % (1 << CW);
    if (r == 0) r = 1;
`ifdef SPAWN_DIFFICULTY_EN
    r = r >> level;
    if (r == 0) r = 1;
`endif
    return r;
  endfunction

  function void m_step();
    bit play, frame, gt;
    int win;
    int r[N];
    logic [N-1:0] ack;
    play  = (state == PLAY);
    frame = enb && p0l0 && play;
    gt    = frame && (m_div == GDIV - 1);
    ack   = ack_drv | (m_vec() & tie_mask);
    win   = -1;
    for (int i = 0; i < N; i++) begin
      r[i] = m_reload(i);
      if (gt && win < 0 && !m_req[i] && !m_idle[i] && m_cnt[i] == 0) win = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m_req[i]) begin
        if (ack[i]) begin m_req[i] = 0; m_idle[i] = 1; end
        else if (!play) begin m_req[i] = 0; m_cnt[i] = 0; end
        else if (slot_active[i]) begin m_req[i] = 0; m_idle[i] = 1; end
      end else if (m_idle[i]) begin
        if (!slot_active[i]) begin m_idle[i] = 0; m_cnt[i] = r[i]; end
      end else if (i == win) m_req[i] = 1;
      else if (gt && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (frame) m_div = (m_div + 1) % GDIV;
    if (p0l0) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  always @(posedge rst) m_reset();

  always @(posedge clk) begin
    if (rst) m_reset();
    else m_step();
    exp_q.push_back(rst ? '0 : m_vec());
  end

  always @(negedge clk) begin
    logic [N-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("spawn_req", 32'(spawn_req), 32'(e));
    end
  end

  task automatic strobe(int period, output logic [N-1:0] rq);
    @(negedge clk); p0l0 = 1'b1;
    @(negedge clk); p0l0 = 1'b0; rq = spawn_req;
    repeat (period - 2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enb = 1'b1; state = PLAY; p0l0 = 1'b0; level = 2'd0;
    slot_active = '0; ack_drv = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_req", 32'(spawn_req), 32'd0);
  endtask

  task automatic run_stagger(string tag);
    logic [N-1:0] rq;
    int f0, f1;
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 12; k++) begin
      strobe(10, rq);
      if (f0 < 0 && rq[0]) f0 = k;
      if (f1 < 0 && rq[1]) f1 = k;
    end
    check({tag, "_first_req0_strobe"}, 32'(f0), 32'd4);
    check({tag, "_first_req1_strobe"}, 32'(f1), 32'd8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    int bad;
    bit found;

    // Reset staggering with ack tied to req
    do_reset(); tie_mask = '1;
    run_stagger("stagger");

    // Arbitration: slots 0 and 1 both pushed to cnt=0 by a pause
    do_reset(); tie_mask = '0;
    for (int k = 0; k < 8; k++) strobe(10, rq);
    check("both_req_before_pause", 32'(rq[1:0]), 32'd3);
    @(negedge clk); state = 3'd2;
    @(negedge clk); check("pause_drops_req", 32'(spawn_req), 32'd0);
    repeat (3) @(negedge clk); state = PLAY;
    strobe(10, rq); check("arb_no_tick", 32'(rq[1:0]), 32'd0);
    strobe(10, rq); check("arb_lowest_wins", 32'(rq[1:0]), 32'd1);
    strobe(10, rq);
    strobe(10, rq); check("arb_next_tick", 32'(rq[1:0]), 32'd3);

    // Handshake hold, release, no re-arm while alive, re-arm after death
    bad = 0;
    for (int k = 0; k < 50; k++) begin strobe(10, rq); if (!rq[0]) bad++; end
    check("hold_req0_50", 32'(bad), 32'd0);
    @(negedge clk); ack_drv[0] = 1'b1; slot_active[0] = 1'b1;
    @(negedge clk); ack_drv[0] = 1'b0; check("ack_release", 32'(spawn_req[0]), 32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin strobe(10, rq); if (rq[0]) bad++; end
    check("no_req_while_alive", 32'(bad), 32'd0);
    @(negedge clk); slot_active[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin strobe(10, rq); if (rq[0]) found = 1; end
    check("rearm_req0", 32'(found), 32'd1);

    // Pause while slot 2 requests
    do_reset(); tie_mask = ~N'(4);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin strobe(10, rq); if (rq[2]) found = 1; end
    check("req2_reached", 32'(found), 32'd1);
    @(negedge clk); state = 3'd2;
    @(negedge clk); check("pause_req2_drop", 32'(spawn_req[2]), 32'd0);
    for (int k = 0; k < 5; k++) strobe(10, rq);
    @(negedge clk); state = PLAY;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin strobe(10, rq); if (rq[2]) found = 1; end
    check("req2_resume", 32'(found), 32'd1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      p0l0    = ($urandom_range(0, 2) == 0);
      enb     = ($urandom_range(0, 7) != 0);
      state   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : PLAY;
      ack_drv = N'($urandom & $urandom & $urandom);
      if ((c % 5) == 0) slot_active = N'($urandom);
      if ((c % 100) == 0) tie_mask = N'($urandom);
      if (!p0l0 && (c % 37) == 0) level = 2'($urandom);
    end

    // Async reset while requests are pending
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      p0l0 = ($urandom_range(0, 2) == 0); state = PLAY; enb = 1'b1;
      slot_active = '0; ack_drv = '0; tie_mask = '0; level = 2'd0;
      if (spawn_req != '0) found = 1;
    end
    check("req_before_async_rst", 32'(found), 32'd1);
    p0l0 = 1'b0;
    #1 rst = 1'b1;
    #1 check("async_rst_clears", 32'(spawn_req), 32'd0);
    #1 rst = 1'b0;
    tie_mask = '1;
    run_stagger("post_rst");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Parametrised spawn timing block for the invader field: one spawn timer per enemy slot, advanced by a shared frame-rate global tick and reloaded with pseudo-random intervals from an internal LFSR. Unlike the fixed 8-slot tick generator, it holds each spawn as a level request until the enemy logic acknowledges it. It re-arms a slot only after that enemy dies, and it grants at most one new spawn per global tick. It sits between the game FSM/VGA timing and the enemy slot logic.

## Interface
- NBR_ENEMIES, 8, number of enemy slots (1..12)
- CNT_W, 4, per-slot timer width; must satisfy 2^CNT_W > 2*NBR_ENEMIES-1 and CNT_W <= 16
- GLOBAL_DIV, 2, qualifying frames per global tick (>=1)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero
- PLAY_STATE, 3'd1, value of `state` in which spawning runs
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- enb  in  1  global enable
- pixel_0_line_0  in  1  one-cycle frame strobe (pixel 0, line 0)
- state  in  3  game FSM state
- level  in  2  difficulty level (used only with SPAWN_DIFFICULTY_EN)
- slot_active  in  NBR_ENEMIES  enemy i alive
- spawn_ack  in  NBR_ENEMIES  enemy logic has taken request i
- spawn_req  out  NBR_ENEMIES  registered spawn request per slot

## Operation
- **Qualifying frame:** `frame = enb & pixel_0_line_0 & (state==PLAY_STATE)`.
- **LFSR (16-bit Fibonacci):**
  - Taps 16,14,13,11; shifts left, feedback into bit 0.
  - Advances on every pixel_0_line_0, independent of enb and state.
- **Global divider:**
  - Counts qualifying frames 0..GLOBAL_DIV-1 and wraps.
  - `gtick = frame & (div==GLOBAL_DIV-1)`. With GLOBAL_DIV=1, gtick equals frame.
- **Reload value for slot i:** `r = lfsr[(i mod (17-CNT_W)) +: CNT_W]`. A value of 0 is forced to 1.
- **Per-slot FSM:**
  - **ARMED:** on gtick, if cnt!=0 then cnt-1; if cnt==0, the slot is eligible.
  - **REQ:** spawn_req[i]=1.
    - spawn_ack[i] -> IDLE.
    - slot_active[i]=1 without ack -> IDLE; the request is dropped.
  - **IDLE:** when slot_active[i]=0 -> ARMED, cnt loaded with r from the current LFSR.
- **Arbitration:** on a gtick, only the lowest-index eligible slot (ARMED, cnt==0) moves to REQ. Other eligible slots stay ARMED with cnt=0 and compete on the next gtick.
- **Pause rule:** in any cycle with state!=PLAY_STATE:
  - every REQ slot returns to ARMED with cnt=0;
  - divider and ARMED counts hold;
  - IDLE slots still re-arm on slot_active low.
- **enb=0:** no frames, so timers and divider hold. REQ slots keep requesting and still accept ack.

## Timing
- **Reset values:**
  - spawn_req=0; all slots ARMED with cnt=2*i+1; divider=0; lfsr=LFSR_SEED.
- **Request latency:** spawn_req[i] rises on the clock edge after the gtick cycle, i.e. one cycle of latency.
- **Release:** on the edge after the spawn_ack[i] cycle, spawn_req[i]=0. An ack while spawn_req[i]=0 is ignored.
- **Re-arm:** IDLE->ARMED on the edge after slot_active[i] is sampled 0.
- **Simultaneous events:**
  - ack and pause in the same cycle -> IDLE; ack wins.
  - gtick and a slot's re-arm in the same cycle -> the slot loads r and does not decrement.
- **Async rst mid-operation:** spawn_req clears immediately, with no clock edge required.

## Configuration
- SPAWN_DIFFICULTY_EN defined: reload is `max(r >> level, 1)`; higher levels give shorter intervals. level must be stable across a frame.
- Not defined: the level port is ignored and reload is r. No logic is generated for the level path.

## Test plan
- **Reset staggering** (defaults, slot_active=0, ack tied to req, state=1, enb=1, strobe every 10 clk):
  - spawn_req[0] rises 1 clk after the 4th strobe;
  - spawn_req[1] rises 1 clk after the 8th strobe;
  - no req before that.
- **Arbitration:** force slots 0 and 1 to reach 0 on the same gtick (e.g. via a seed/reset condition).
  - Only req[0] asserts on that gtick.
  - req[1] asserts on the following gtick.
- **Handshake hold:** withhold spawn_ack[0] for 50 strobes -> req[0] stays 1 throughout. Ack -> req[0]=0 one clk later, slot IDLE.
- **Pause:**
  - While req[2]=1, set state=3'd2 -> req[2]=0 next clk; the divider value is unchanged over 5 strobes.
  - Return to state=1 -> req[2]=1 one clk after the next gtick.
- **Re-arm and reload:**
  - After ack, hold slot_active[0]=1 for 10 strobes -> no req.
  - Drop slot_active[0] -> cnt equals the LFSR slice (checked by model), nonzero; req follows after cnt+1 gticks.
- **SPAWN_DIFFICULTY_EN:**
  - level=2, slice value 12 -> reload 3.
  - slice value 2 -> reload 1 (clamped).
  - Async rst pulse mid-count -> req=0 immediately; reset values restored.
